fast_corner_axis_packer: RTL

Packs the NMS-filtered corner stream (valid flag, x/y coordinate, score) into framed 32-bit AXI4-Stream words for the DMA S2MM path. Each frame is a header word, one or two words per corner, and a trailer carrying accepted/dropped counts with `tlast`. Corners are buffered in a parametrised FIFO so output backpressure does not stall the pixel pipeline. Excess corners beyond a per-frame cap, or arriving while the FIFO is full, are dropped and counted. The block sits between `NMS_top` and the outbound AXI-Stream FIFO of the FAST top level.

---
 rtl/fast_corner_axis_packer.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fast_corner_axis_packer.sv
// Packs NMS corners into framed 32-bit AXI4-Stream words: header, one or two
// words per corner from a backpressure FIFO, then a counted trailer with tlast.
module fast_corner_axis_packer #(
  parameter int unsigned COORD_W     = 10,
  parameter int unsigned SCORE_W     = 13,
  parameter int unsigned FIFO_DEPTH  = 64,
  parameter int unsigned MAX_CORNERS = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic               sof,
  input  logic               eof,
  input  logic               score_en,
  input  logic               corner_in,
  input  logic [COORD_W-1:0] x_coord,
  input  logic [COORD_W-1:0] y_coord,
  input  logic [SCORE_W-1:0] score,
  output logic [31:0]        m_axis_tdata,
  output logic [3:0]         m_axis_tkeep,
  output logic               m_axis_tlast,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               frame_done,
  output logic [15:0]        drop_cnt,
  output logic               proto_err
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned ENT_W = 2 * COORD_W + SCORE_W;
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [15:0]   MAX_ACC   = 16'(MAX_CORNERS);
  localparam logic [15:0]   HDR_MAGIC = 16'hFA57;

  typedef enum logic [1:0] {IDLE, HEADER, STREAM, TRAILER} state_e;

  state_e           state_q, state_d;
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             frame_active_q, frame_active_d;
  logic             score_en_q, score_en_d;
  logic             score_pend_q, score_pend_d;
  logic [15:0]      acc_q, acc_d;
  logic [15:0]      drop_q, drop_d;
  logic [15:0]      frame_id_q, frame_id_d;
  logic [31:0]      tdata_q, tdata_d;
  logic [3:0]       tkeep_q, tkeep_d;
  logic             tlast_q, tlast_d;
  logic             tvalid_q, tvalid_d;
  logic             frame_done_q, frame_done_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic             proto_err_q, proto_err_d;

  logic             start_c;
  logic             push_c;
  logic             pop_c;
  logic             out_free_c;
  logic             fifo_full_c;
  logic             fifo_empty_c;
  logic [ENT_W-1:0] head_c;
  logic [COORD_W-1:0] head_x_c;
  logic [COORD_W-1:0] head_y_c;
  logic [SCORE_W-1:0] head_s_c;

  assign fifo_full_c  = (cnt_q == FULL_CNT);
  assign fifo_empty_c = (cnt_q == '0);
  assign head_c       = mem[rd_ptr_q];
  assign head_x_c     = head_c[COORD_W-1:0];
  assign head_y_c     = head_c[2*COORD_W-1:COORD_W];
  assign head_s_c     = head_c[ENT_W-1:2*COORD_W];
  assign out_free_c   = !tvalid_q || m_axis_tready;
  assign start_c      = ce && sof && (state_q == IDLE);

  // Corner storage; entries are {score, y, x}. Contents need no reset.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr_q] <= {score, y_coord, x_coord};
    end
  end

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    cnt_d          = cnt_q;
    frame_active_d = frame_active_q;
    score_en_d     = score_en_q;
    score_pend_d   = score_pend_q;
    acc_d          = acc_q;
    drop_d         = drop_q;
    frame_id_d     = frame_id_q;
    tdata_d        = tdata_q;
    tkeep_d        = tkeep_q;
    tlast_d        = tlast_q;
    tvalid_d       = tvalid_q;
    frame_done_d   = 1'b0;
    drop_cnt_d     = drop_cnt_q;
    proto_err_d    = proto_err_q;
    push_c         = 1'b0;
    pop_c          = 1'b0;

    if (ce && sof && (state_q != IDLE)) begin
      proto_err_d = 1'b1;
    end

    if (start_c) begin
      score_en_d     = score_en;
      frame_active_d = 1'b1;
      acc_d          = '0;
      drop_d         = '0;
    end

    // Accept rule: a corner in the sof cycle already belongs to the new frame.
    if (ce && corner_in && (frame_active_q || start_c)) begin
      if (!fifo_full_c && (acc_d < MAX_ACC)) begin
        push_c = 1'b1;
        acc_d  = acc_d + 16'd1;
      end else if (drop_d != 16'hFFFF) begin
        drop_d = drop_d + 16'd1;
      end
    end

    if (ce && eof && (frame_active_q || start_c)) begin
      frame_active_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (start_c) begin
          tdata_d  = {HDR_MAGIC, frame_id_q};
          tkeep_d  = 4'hF;
          tlast_d  = 1'b0;
          tvalid_d = 1'b1;
          state_d  = HEADER;
        end
      end
      HEADER, STREAM: begin
        if (out_free_c) begin
          state_d  = STREAM;
          tvalid_d = 1'b0;
          tkeep_d  = 4'h0;
          tlast_d  = 1'b0;
          if (score_pend_q) begin
            tdata_d      = 32'(head_s_c);
            tkeep_d      = 4'hF;
            tvalid_d     = 1'b1;
            score_pend_d = 1'b0;
            pop_c        = 1'b1;
          end else if (!fifo_empty_c) begin
            tdata_d  = {16'(head_y_c), 16'(head_x_c)};
            tkeep_d  = 4'hF;
            tvalid_d = 1'b1;
            if (score_en_q) begin
              score_pend_d = 1'b1;
            end else begin
              pop_c = 1'b1;
            end
          end else if (!frame_active_q) begin
            tdata_d  = {acc_q, drop_q};
            tkeep_d  = 4'hF;
            tlast_d  = 1'b1;
            tvalid_d = 1'b1;
            state_d  = TRAILER;
          end
        end
      end
      TRAILER: begin
        if (m_axis_tready) begin
          tvalid_d     = 1'b0;
          tkeep_d      = 4'h0;
          tlast_d      = 1'b0;
          frame_done_d = 1'b1;
          drop_cnt_d   = drop_q;
          frame_id_d   = frame_id_q + 16'd1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Occupancy uses the registered count, so a pop never frees room for a same-cycle push.
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_c && !pop_c) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!push_c && pop_c) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      cnt_q          <= '0;
      frame_active_q <= 1'b0;
      score_en_q     <= 1'b0;
      score_pend_q   <= 1'b0;
      acc_q          <= '0;
      drop_q         <= '0;
      frame_id_q     <= '0;
      tdata_q        <= '0;
      tkeep_q        <= '0;
      tlast_q        <= 1'b0;
      tvalid_q       <= 1'b0;
      frame_done_q   <= 1'b0;
      drop_cnt_q     <= '0;
      proto_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      cnt_q          <= cnt_d;
      frame_active_q <= frame_active_d;
      score_en_q     <= score_en_d;
      score_pend_q   <= score_pend_d;
      acc_q          <= acc_d;
      drop_q         <= drop_d;
      frame_id_q     <= frame_id_d;
      tdata_q        <= tdata_d;
      tkeep_q        <= tkeep_d;
      tlast_q        <= tlast_d;
      tvalid_q       <= tvalid_d;
      frame_done_q   <= frame_done_d;
      drop_cnt_q     <= drop_cnt_d;
      proto_err_q    <= proto_err_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign frame_done    = frame_done_q;
  assign drop_cnt      = drop_cnt_q;
  assign proto_err     = proto_err_q;

endmodule
